// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame timing.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DEF_CLKS_PER_BIT = 434;  // 50 MHz / 115200
    localparam int DEF_DATA_BITS    = 8;

    // Distance from the start edge to the middle of the start bit.
    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Serial input and received-word outputs of the UART receiver.
interface uart_rx_core_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS
);
    logic                 rx_s;
    logic                 start_fall;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output rx_s, start_fall,
        input  rx_data, rx_valid, frame_err, busy
    );

    modport slave (
        input  rx_s, start_fall,
        output rx_data, rx_valid, frame_err, busy
    );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period counter: pulses sample_tick once per interval, restarting after every tick.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int CW           = $clog2(CLKS_PER_BIT),
    parameter int IW           = $clog2(CLKS_PER_BIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic [IW-1:0] interval,
    output logic          sample_tick
);

    logic [CW-1:0] cnt_q;

    // Counter value k means k cycles have elapsed since the last clear or tick.
    assign sample_tick = !clear && (IW'(cnt_q) == interval - IW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clear || sample_tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// UART receive deserializer: frames from the start_fall pulse, mid-bit sampling, LSB first.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEF_DATA_BITS
) (
    input logic           clk,
    input logic           rst,
    uart_rx_core_if.slave rx_if
);

    localparam int HALF = half_bit(CLKS_PER_BIT);
    localparam int IW   = $clog2(CLKS_PER_BIT + 1);
    localparam int BW   = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_t            state_q, state_d;
    logic [BW-1:0]        bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, frame_err_q;

    logic                 tick;
    logic                 timer_clr;
    logic [IW-1:0]        interval;
    logic                 shift_en, idx_clr, valid_d, err_d;

    // Holding the timer clear through IDLE makes START begin at count 0 in cycle 1.
    assign timer_clr = (state_q == IDLE);
    assign interval  = (state_q == START) ? IW'(HALF) : IW'(CLKS_PER_BIT);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (timer_clr),
        .interval    (interval),
        .sample_tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_en = 1'b0;
        idx_clr  = 1'b0;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_if.start_fall) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_if.rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_clr = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_en = 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // STOP lasts through the strobe cycle so busy covers it.
                if (rx_valid_q || frame_err_q) begin
                    state_d = IDLE;
                end else if (tick) begin
                    valid_d = rx_if.rx_s;
                    err_d   = !rx_if.rx_s;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= valid_d;
            frame_err_q <= err_d;
            if (idx_clr) begin
                bit_idx_q <= '0;
            end else if (shift_en) begin
                bit_idx_q <= bit_idx_q + BW'(1);
            end
            if (shift_en) begin
                shift_q <= {rx_if.rx_s, shift_q[DATA_BITS-1:1]};
            end
            if (valid_d) begin
                rx_data_q <= shift_q;
            end
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core: directed frame table, hand sequences, random frames vs a timeline model.
module tb_uart_rx_core;
    import uart_pkg::*;

    localparam int CPB    = 16;
    localparam int DB     = 8;
    localparam int HALF   = CPB / 2;
    localparam int STROBE = HALF + (DB + 1) * CPB + 1;
    localparam int MAXC   = 16384;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_core_if #(.DATA_BITS(DB)) rif ();

    uart_rx_core #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .rx_if (rif)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int t        = 0;
    logic hist [MAXC];
    logic prev_line = 1'b1;

    // Reference model: a frame accepted at cycle m_t0, judged from the recorded line.
    logic          m_active = 1'b0;
    int            m_t0     = 0;
    logic [DB-1:0] m_data   = '0;

    int obs_v, obs_e, last_strobe_t, last_valid_t, prev_valid_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         low;
        int         gap;
        int         exp_v;
        int         exp_e;
        logic [7:0] exp_data;
        int         exp_lat;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
        end
    endtask

    task automatic cycle(input logic line, input logic r);
        int   k;
        logic fs, eb, ev, ee, sf;
        @(posedge clk);
        #1;
        if (t >= MAXC) begin
            $display("FAIL cycle_budget t=%0d actual=%0d required<%0d", t, t, MAXC);
            $fatal(1, "cycle budget exceeded");
        end
        eb = 1'b0; ev = 1'b0; ee = 1'b0;
        if (m_active) begin
            k  = t - m_t0;
            fs = (k > HALF) && hist[m_t0 + HALF];
            eb = (k >= 1) && ((k <= HALF) || (!fs && k <= STROBE));
            if (!fs && k == STROBE) begin
                ev = hist[m_t0 + STROBE - 1];
                ee = !ev;
                if (ev) begin
                    for (int i = 0; i < DB; i++) m_data[i] = hist[m_t0 + HALF + (i + 1) * CPB];
                end
            end
            if (k > 0 && !eb) m_active = 1'b0;
        end
        chk("busy", 32'(rif.busy), 32'(eb));
        chk("rx_valid", 32'(rif.rx_valid), 32'(ev));
        chk("frame_err", 32'(rif.frame_err), 32'(ee));
        chk("rx_data", 32'(rif.rx_data), 32'(m_data));
        if (rif.rx_valid === 1'b1) begin
            obs_v++;
            prev_valid_t  = last_valid_t;
            last_valid_t  = t;
            last_strobe_t = t;
        end
        if (rif.frame_err === 1'b1) begin
            obs_e++;
            last_strobe_t = t;
        end
        sf             = prev_line & ~line;
        rst            = r;
        rif.rx_s       = line;
        rif.start_fall = sf;
        hist[t]        = line;
        prev_line      = line;
        if (r) begin
            m_active = 1'b0;
            m_data   = '0;
        end else if (!m_active && sf) begin
            m_active = 1'b1;
            m_t0     = t;
        end
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
    endtask

    // One frame: start bit, data LSB first, stop level held stop_len cycles; abort_at >= 0 resets there.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len, input int abort_at);
        int   n;
        int   len;
        logic lvl;
        n = 0;
        for (int b = 0; b < DB + 2; b++) begin
            lvl = (b == 0) ? 1'b0 : (b <= DB) ? d[b-1] : stop;
            len = (b == DB + 1) ? stop_len : CPB;
            for (int c = 0; c < len; c++) begin
                if (n == abort_at) begin
                    cycle(1'b1, 1'b1);
                    cycle(1'b1, 1'b1);
                    cycle(1'b1, 1'b0);
                    return;
                end
                cycle(lvl, 1'b0);
                n++;
            end
        end
    endtask

    task automatic clear_obs();
        obs_v = 0; obs_e = 0;
        last_strobe_t = -1; last_valid_t = -1; prev_valid_t = -1;
    endtask

    initial begin
        int         st;
        logic [7:0] d;
        int         kind;
        logic       s;

        rif.rx_s       = 1'b1;
        rif.start_fall = 1'b0;
        clear_obs();

        // Reset held while the line toggles.
        for (int i = 0; i < 6; i++) cycle(1'($urandom_range(0, 1)), 1'b1);
        chk("reset rx_data", 32'(rif.rx_data), 32'h0);
        chk("reset busy", 32'(rif.busy), 32'h0);
        chk("reset rx_valid", 32'(rif.rx_valid), 32'h0);
        chk("reset frame_err", 32'(rif.frame_err), 32'h0);
        cycle(1'b1, 1'b0);
        idle(5);
        chk("post-reset busy", 32'(rif.busy), 32'h0);

        tbl[0] = '{8'hA5, 1'b1, 0, 4, 1, 0, 8'hA5, 153};
        tbl[1] = '{8'h5A, 1'b0, 0, 4, 0, 1, 8'hA5, 153};
        tbl[2] = '{8'h00, 1'b1, 4, 12, 0, 0, 8'hA5, -1};
        tbl[3] = '{8'h3C, 1'b1, 0, 4, 1, 0, 8'h3C, 153};

        for (int i = 0; i < 4; i++) begin
            clear_obs();
            st = t;
            if (tbl[i].low > 0) begin
                for (int j = 0; j < tbl[i].low; j++) cycle(1'b0, 1'b0);
            end else begin
                send_frame(tbl[i].data, tbl[i].stop, CPB, -1);
            end
            idle(tbl[i].gap);
            chk($sformatf("vec%0d valid_count", i), 32'(obs_v), 32'(tbl[i].exp_v));
            chk($sformatf("vec%0d err_count", i), 32'(obs_e), 32'(tbl[i].exp_e));
            chk($sformatf("vec%0d rx_data", i), 32'(rif.rx_data), 32'(tbl[i].exp_data));
            if (tbl[i].exp_lat >= 0)
                chk($sformatf("vec%0d latency", i), 32'(last_strobe_t - st), 32'(tbl[i].exp_lat));
        end

        // Break: line stays low well past the stop sample.
        clear_obs();
        send_frame(8'h00, 1'b0, 300, -1);
        idle(10);
        chk("break err_count", 32'(obs_e), 32'd1);
        chk("break valid_count", 32'(obs_v), 32'd0);
        chk("break rx_data", 32'(rif.rx_data), 32'h3C);

        // Back-to-back: next start edge in the first cycle after the strobe.
        clear_obs();
        send_frame(8'h00, 1'b1, HALF + 2, -1);
        send_frame(8'hFF, 1'b1, CPB, -1);
        idle(4);
        chk("b2b valid_count", 32'(obs_v), 32'd2);
        chk("b2b spacing", 32'(last_valid_t - prev_valid_t), 32'd154);
        chk("b2b rx_data", 32'(rif.rx_data), 32'hFF);

        // Reset in the middle of a frame, then the same frame cleanly.
        clear_obs();
        send_frame(8'h81, 1'b1, CPB, 60);
        chk("abort rx_data", 32'(rif.rx_data), 32'h0);
        chk("abort busy", 32'(rif.busy), 32'h0);
        idle(200);
        chk("abort strobes", 32'(obs_v + obs_e), 32'd0);
        send_frame(8'h81, 1'b1, CPB, -1);
        idle(4);
        chk("after-abort valid_count", 32'(obs_v), 32'd1);
        chk("after-abort rx_data", 32'(rif.rx_data), 32'h81);

        // Random frames, false starts, bad stop bits and ragged gaps.
        for (int n = 0; n < 25; n++) begin
            d    = 8'($urandom);
            kind = $urandom_range(0, 7);
            if (kind == 0) begin
                for (int j = 0; j < int'($urandom_range(1, HALF)); j++) cycle(1'b0, 1'b0);
                idle($urandom_range(1, HALF + 6));
            end else begin
                s = (kind != 1);
                send_frame(d, s, $urandom_range(HALF + 2, 2 * CPB), -1);
                idle(s ? $urandom_range(0, 5) : $urandom_range(1, 5));
            end
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
